// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage controller. Runs loads/stores as req/ack transactions
//               while stalling the pipeline, and produces PCSrc for taken
//               branches. Optional macro MEM_TIMEOUT_EN adds a WAIT-cycle abort.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] read_data,
    output logic              PCSrc,
    output logic              stall,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              w_op;
    logic              w_stall;
    logic              w_timeout;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_readData;

    if (TIMEOUT < 1) begin : g_timeoutRangeCheck
        $error("mem_stage_ctrl: TIMEOUT must be >= 1");
    end

    assign w_op = MemRead | MemWrite;

`ifdef MEM_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    // Abort on the cycle that would take the count to TIMEOUT; an ack here still wins.
    assign w_timeout = (r_state == S_WAIT) && !mem_ack &&
                       (r_cnt == c_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != S_WAIT) begin
                r_cnt <= '0;
            end else if (!mem_ack) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_op;
                if (w_op) begin
                    w_stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_stateNext = S_DONE;
                end
            end
            // Inputs still show the finished op here, so never reissue from DONE.
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_readData <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_op) begin
                        r_addr  <= alu_result;
                        r_wdata <= write_data;
                        r_we    <= MemWrite;
                        r_req   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_readData <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_req <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign read_data = r_readData;
    assign stall     = w_stall;
    assign PCSrc     = Branch & Zero & ~w_stall;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Self-checking bench for mem_stage_ctrl: vector table with a
//               read_data scoreboard plus hand-written reset/branch/timeout cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic        Zero;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] read_data;
    logic        PCSrc;
    logic        stall;
    logic        mem_err;

    int nTests = 0;
    int nFail  = 0;

    logic [31:0] sbQ[$];
    logic [31:0] modelRd;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        br;
        logic        zr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ackDelay;
        logic        expWe;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[6];

    mem_stage_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Branch    (Branch),
        .Zero      (Zero),
        .alu_result(alu_result),
        .write_data(write_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .read_data (read_data),
        .PCSrc     (PCSrc),
        .stall     (stall),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic runVec(input vec_t v);
        logic [31:0] expRd;
        @(negedge clk);
        MemRead    = v.rd;
        MemWrite   = v.wr;
        Branch     = v.br;
        Zero       = v.zr;
        alu_result = v.addr;
        write_data = v.wdata;
        mem_ack    = 1'b0;
        sbQ.push_back(v.expRead);
        #1;
        check("issue_stall", stall, 1);
        check("issue_req", mem_req, 0);
        check("issue_pcsrc", PCSrc, 0);
        for (int k = 1; k <= v.ackDelay; k++) begin
            @(negedge clk);
            if (k == v.ackDelay) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            #1;
            check("wait_stall", stall, 1);
            check("wait_req", mem_req, 1);
            check("wait_addr", mem_addr, v.addr);
            check("wait_we", mem_we, v.expWe);
            check("wait_pcsrc", PCSrc, 0);
            if (v.wr) check("wait_wdata", mem_wdata, v.wdata);
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        #1;
        check("done_stall", stall, 0);
        check("done_req", mem_req, 0);
        check("done_pcsrc", PCSrc, v.br & v.zr);
        expRd = sbQ.pop_front();
        check("done_read_data", read_data, expRd);
        modelRd = expRd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 0, 0, 0, 32'h40, 32'h0,    32'hDEADBEEF, 3, 0, 32'hDEADBEEF};
        vecs[1] = '{0, 1, 0, 0, 32'h10, 32'h1234, 32'hFFFF0000, 1, 1, 32'hDEADBEEF};
        vecs[2] = '{1, 0, 0, 0, 32'h80, 32'h0,    32'hA5A5A5A5, 1, 0, 32'hA5A5A5A5};
        vecs[3] = '{1, 1, 0, 0, 32'h84, 32'h55,   32'h12345678, 2, 1, 32'hA5A5A5A5};
        vecs[4] = '{1, 0, 1, 1, 32'h08, 32'h0,    32'h0BADF00D, 2, 0, 32'h0BADF00D};
        vecs[5] = '{1, 0, 1, 0, 32'h0C, 32'h0,    32'h00000001, 1, 0, 32'h00000001};

        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; Zero = 1'b0;
        alu_result = '0; write_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        modelRd = '0;
        #12;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_read_data", read_data, 0);
        check("rst_stall", stall, 0);
        check("rst_err", mem_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) runVec(vecs[i]);

        // Branch taken with no memory op resolves immediately.
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b1; Zero = 1'b1;
        #1;
        check("br_pcsrc", PCSrc, 1);
        check("br_stall", stall, 0);
        @(negedge clk);
        Branch = 1'b0; Zero = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        check("br_no_req", mem_req, 0);
        check("idle_ack_stall", stall, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_read_data", read_data, modelRd);

        // Reset while waiting for an ack.
        @(negedge clk);
        MemRead = 1'b1; alu_result = 32'h40;
        @(negedge clk);
        #1;
        check("mid_req", mem_req, 1);
        #2;
        rst_n = 1'b0;
        MemRead = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_read_data", read_data, 0);
        check("mid_rst_stall", stall, 0);
        modelRd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_stall", stall, 0);
        check("post_rst_req", mem_req, 0);

`ifdef MEM_TIMEOUT_EN
        runVec('{1, 0, 0, 0, 32'h20, 32'h0, 32'h77778888, 4, 0, 32'h77778888});
        check("to_ack4_err", mem_err, 0);
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; alu_result = 32'h24; mem_ack = 1'b0;
        #1;
        check("to_issue_stall", stall, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            check("to_wait_req", mem_req, 1);
            check("to_wait_err", mem_err, 0);
        end
        @(negedge clk);
        #1;
        check("to_done_req", mem_req, 0);
        check("to_done_err", mem_err, 1);
        check("to_done_stall", stall, 0);
        check("to_read_data", read_data, 32'h77778888);
        @(negedge clk);
        MemRead = 1'b0;
        #1;
        @(negedge clk);
        #1;
        check("to_err_sticky", mem_err, 1);
`else
        check("no_macro_err", mem_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM control pipeline register. Takes the registered MemRead/MemWrite/Branch controls plus the ALU address and store data.
- Runs each access as a multi-cycle req/ack transaction to the data memory, stalling the pipeline until the access completes.
- Captures load data for the MEM/WB boundary and produces PCSrc for taken branches.

Parameters:
ADDR_W, 32, address width (ALU result width)
DATA_W, 32, data word width
TIMEOUT, 16, WAIT-cycle limit before abort (used only with MEM_TIMEOUT_EN; must be >= 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
MemRead  in  1  load request from EX/MEM register
MemWrite  in  1  store request from EX/MEM register
Branch  in  1  branch instruction flag from EX/MEM register
Zero  in  1  ALU zero flag
alu_result  in  ADDR_W  memory address
write_data  in  DATA_W  store data
mem_req  out  1  request to data memory, registered
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_ack  in  1  one-cycle completion pulse from memory
mem_rdata  in  DATA_W  read data; valid with mem_ack
read_data  out  DATA_W  last completed load data, registered
PCSrc  out  1  branch taken, combinational
stall  out  1  freeze upstream pipeline registers, combinational
mem_err  out  1  sticky timeout error; constant 0 without macro

Behaviour:
Upstream contract:
- Upstream holds every input stable while stall=1.

Reset (rst_n=0, asynchronous):
- state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read_data=0, mem_err=0.
- Reset mid-transaction drops mem_req immediately and discards the access; no retry after reset.
- The memory side must tolerate an abandoned request.

FSM:
- IDLE:
  - op = MemRead | MemWrite.
  - If op=1: latch alu_result into mem_addr and write_data into mem_wdata; set mem_we = MemWrite; set mem_req<=1; go to WAIT.
  - If op=0: remain in IDLE.
- WAIT:
  - mem_req held at 1; address/data/we held stable.
  - On mem_ack: mem_req<=0; if mem_we=0, read_data<=mem_rdata; go to DONE.
- DONE:
  - One cycle. Go to IDLE unconditionally; inputs are ignored, because they still carry the just-finished op while the pipeline advances on this edge.

Stall and branch outputs:
- stall = (IDLE & op) | WAIT. stall=0 in DONE.
- PCSrc = Branch & Zero & ~stall.

Latency:
- Minimum stall is 2 cycles (IDLE issue + WAIT with immediate ack).
- In general, stall = 1 + number of WAIT cycles up to and including the ack cycle.

Boundary cases:
- MemRead & MemWrite both 1: treated as a write; read_data unchanged.
- mem_ack in IDLE or DONE: ignored.
- mem_rdata on a write ack: ignored.
- Back-to-back ops: every op passes through DONE, so there is one non-stalled cycle between transactions; no request is issued in DONE.
- read_data holds its value until the next completed load.

Optional Feature:
Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the counter reaches TIMEOUT with no ack: mem_req<=0, mem_err<=1 (sticky until reset), go to DONE, read_data unchanged.
  - An ack in the same cycle as the limit wins (normal completion, no error).
- Not defined:
  - No counter; WAIT lasts indefinitely.
  - mem_err tied to 0.

Test Plan:
1. Assert MemRead=1, alu_result=0x40, then pull rst_n low during WAIT → mem_req=0 and read_data=0 immediately; after release with MemRead=0, state=IDLE and stall=0.
2. Load: MemRead=1, alu_result=0x40, mem_ack on the 3rd WAIT cycle with mem_rdata=0xDEADBEEF → mem_addr=0x40, mem_we=0, stall high 4 cycles, read_data=0xDEADBEEF from the DONE cycle onward.
3. Store: MemWrite=1, alu_result=0x10, write_data=0x1234, ack in the first WAIT cycle → mem_we=1, mem_wdata=0x1234, mem_req high exactly 1 cycle, stall high 2 cycles.
4. MemRead=MemWrite=1, read_data preloaded to 0xA5A5A5A5 → mem_we=1, read_data remains 0xA5A5A5A5 after ack.
5. Branch=1, Zero=1, no mem op → PCSrc=1 in the same cycle, stall=0; add MemRead=1 → PCSrc=0 through the stall, then PCSrc=1 in the DONE cycle.
6. MEM_TIMEOUT_EN defined, TIMEOUT=4, MemRead=1, no ack → mem_req drops after 4 WAIT cycles, mem_err=1 and stays 1, stall=0 in the following (DONE) cycle; repeat with ack on cycle 4 → mem_err stays 0.
